// File: rtl/carry4_cin_sweep_ctrl_if.sv
// Bus between the CARRY4 sweep sequencer and the CARRY4 under test plus its
// start/status handshake. master = sequencer side, slave = CARRY4/observer side.
interface carry4_cin_sweep_ctrl_if #(
    parameter int ERR_W = 16
) ();
    logic             start;
    logic             carry_ci;
    logic             carry_cyinit;
    logic [3:0]       carry_di;
    logic [3:0]       carry_s;
    logic [3:0]       carry_o;
    logic [3:0]       carry_co;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             err_sat;
    logic [9:0]       first_fail_vec;

    modport master (
        input  start, carry_o, carry_co,
        output carry_ci, carry_cyinit, carry_di, carry_s,
        output busy, done, pass, err_count, err_sat, first_fail_vec
    );

    modport slave (
        output start, carry_o, carry_co,
        input  carry_ci, carry_cyinit, carry_di, carry_s,
        input  busy, done, pass, err_count, err_sat, first_fail_vec
    );
endinterface

// File: rtl/carry4_cin_sweep_ctrl.sv
// Sweeps all 1024 carry-in/DI/S vectors into an external CARRY4, waits SETTLE
// cycles per vector, compares O/CO against a reference carry chain and keeps a
// saturating failure count plus the index of the first failing vector.
module carry4_cin_sweep_ctrl #(
    parameter int SETTLE = 2,
    parameter int ERR_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    carry4_cin_sweep_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0]       WAIT_LAST = 8'(SETTLE - 1);
    localparam logic [9:0]       VEC_LAST  = 10'd1023;
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [9:0]       r_vec;
    logic [7:0]       r_wait;
    logic             r_ci;
    logic             r_cyinit;
    logic [3:0]       r_di;
    logic [3:0]       r_s;
    logic             r_busy;
    logic             r_done;
    logic [ERR_W-1:0] r_err;
    logic [9:0]       r_ffv;
    logic [7:0]       w_exp;
    logic             w_fail;
    logic             w_sat;

    // Reference CARRY4: returns {O[3:0], CO[3:0]} for vector {src_sel, cin, di, s}.
    function automatic logic [7:0] carry_model(input logic [9:0] v);
        logic [4:0] c;
        logic [3:0] o;
        c[0] = v[8];
        for (int i = 0; i < 4; i++) begin
            c[i+1] = v[i] ? c[i] : v[4+i];
            o[i]   = v[i] ^ c[i];
        end
        return {o, c[4:1]};
    endfunction

    assign w_exp  = carry_model(r_vec);
    assign w_fail = ({bus.carry_o, bus.carry_co} != w_exp);
    assign w_sat  = &r_err;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; start is only honoured from IDLE or DONE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_DRIVE;
            S_DRIVE: w_next = S_WAIT;
            S_WAIT:  if (r_wait == WAIT_LAST) w_next = S_CHECK;
            S_CHECK: w_next = (r_vec == VEC_LAST) ? S_DONE : S_DRIVE;
            S_DONE:  if (bus.start) w_next = S_DRIVE;
            default: w_next = S_IDLE;
        endcase
    end

    // Vector counter, drive registers, settle counter and result bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec    <= '0;
            r_wait   <= '0;
            r_ci     <= 1'b0;
            r_cyinit <= 1'b0;
            r_di     <= '0;
            r_s      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= '0;
            r_ffv    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_vec  <= '0;
                        r_err  <= '0;
                        r_ffv  <= '0;
                        r_done <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    // src_sel picks which carry input carries cin; the other stays 0.
                    r_ci     <= ~r_vec[9] & r_vec[8];
                    r_cyinit <=  r_vec[9] & r_vec[8];
                    r_di     <= r_vec[7:4];
                    r_s      <= r_vec[3:0];
                    r_wait   <= '0;
                end
                S_WAIT: begin
                    r_wait <= r_wait + 8'd1;
                end
                S_CHECK: begin
                    if (w_fail) begin
                        if (!w_sat)        r_err <= r_err + ERR_ONE;
                        if (r_err == '0)   r_ffv <= r_vec;
                    end
                    if (r_vec == VEC_LAST) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_ci     <= 1'b0;
                        r_cyinit <= 1'b0;
                        r_di     <= '0;
                        r_s      <= '0;
                    end else begin
                        r_vec <= r_vec + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.carry_ci       = r_ci;
    assign bus.carry_cyinit   = r_cyinit;
    assign bus.carry_di       = r_di;
    assign bus.carry_s        = r_s;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_done & (r_err == '0);
    assign bus.err_count      = r_err;
    assign bus.err_sat        = w_sat;
    assign bus.first_fail_vec = r_ffv;

endmodule
